timer_sched_ctrl: RTL and testbench
===================================

Name: timer_sched_ctrl

Overview:
- Programmable timer controller. Sequences a 32-bit tick counter through a prescaler, compares it against a software-set compare value and raises a level interrupt.
- Sits on the SoC peripheral bus next to the console. Software configures it through a single-cycle req/ack register interface.
- Replaces free-running fixed-divider time keeping with software-controlled period, enable and interrupt acknowledge.

Parameters:
- ADDR_W, 3, width of the word-address field used for register decode (addr_in[ADDR_W+1:2]).
- PRESCALE_RST, 32'd999, reset value of PRESCALE (1000-cycle tick).

Ports:
- clk_in  input  1  system clock, all state on the rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- req_in  input  1  bus request, one-cycle pulse per access.
- we_in  input  1  1 = write, 0 = read; valid with req_in.
- addr_in  input  32  byte address; bits [4:2] select the register, other bits ignored.
- wdata_in  input  32  write data.
- rdata_out  output  32  read data, valid while ack_out=1.
- ack_out  output  1  access complete, one-cycle pulse.
- time_clk_out  output  32  current COUNT value.
- irq_out  output  1  level interrupt = STATUS.pending AND CTRL.irq_en.

Behaviour:
- Reset (async, reset_in=1):
  - COUNT=0, pre_cnt=0, COMPARE=32'hFFFFFFFF, PRESCALE=PRESCALE_RST, CTRL=0, pending=0.
  - ack_out=0, rdata_out=0, irq_out=0, FSM=IDLE.
  - Reset asserted mid-access drops the pending ack.
- Register map (word index):
  - 0 CTRL: [0] enable, [1] irq_en, [2] oneshot, rest reads 0.
  - 1 PRESCALE.
  - 2 COUNT (R/W).
  - 3 COMPARE.
  - 4 STATUS: [0] pending, write-1-to-clear.
  - 5-7: reads return 0, writes ignored, still acked.
- Bus handshake:
  - req_in sampled at edge N; ack_out=1 during cycle N+1 only.
  - Read data is captured at edge N and returned in rdata_out with ack. rdata_out=0 when ack_out=0.
  - Writes take effect at edge N.
  - Back-to-back req_in every cycle is legal; each access gets its own ack.
- FSM states:
  - IDLE: enable=0, counter frozen. Goes to RUN when a CTRL write sets enable.
  - RUN: prescaler active. Goes to IDLE when enable is cleared. Goes to DONE on a match when oneshot=1.
  - DONE: counter frozen at 0, enable bit auto-cleared. Goes to RUN when a CTRL write sets enable.
- Tick and compare, in RUN:
  - pre_cnt increments each cycle. When pre_cnt==PRESCALE, pre_cnt goes to 0 and a tick occurs.
  - On a tick: if COUNT==COMPARE, COUNT goes to 0 and pending goes to 1 (match); otherwise COUNT increments.
  - Period = (COMPARE+1)*(PRESCALE+1) clocks. PRESCALE=0 gives a tick every cycle.
  - COUNT wraps 32'hFFFFFFFF to 0 with no match unless COMPARE=32'hFFFFFFFF.
- Register writes:
  - A PRESCALE write clears pre_cnt.
  - A COMPARE write below the current COUNT: no match until wrap.
- Simultaneous events:
  - A software COUNT write in the same cycle as a tick: the write wins and pre_cnt clears.
  - A STATUS clear in the same cycle as a match: the set wins, pending stays 1.
  - A CTRL write clearing enable in the same cycle as a tick: the tick is discarded.
- irq_out is combinational from registered pending and irq_en, with no extra latency.

Optional Feature:
- Macro: TIMER_SCHED_CTRL_ONESHOT_EN.
- Defined: CTRL[2] is writable, and the DONE state and auto-clear of enable exist as described.
- Undefined: CTRL[2] reads 0 and writes are ignored. The DONE state is not implemented, and every match reloads COUNT to 0 and keeps running (periodic only).

Test Plan:
- Reset and readback: assert reset_in mid-run, then read all registers -> CTRL=0, PRESCALE=999, COUNT=0, COMPARE=FFFFFFFF, STATUS=0, ack_out exactly 1 cycle after each req_in.
- Periodic irq: PRESCALE=3, COMPARE=4, CTRL=3 -> first pending and irq_out after 20 clocks; COUNT sequence 0,1,2,3,4,0; pending set again every 20 clocks.
- Write-1-clear race: clear STATUS in the match cycle -> pending stays 1. Clear one cycle later -> pending 0, irq_out 0. Set irq_en=0 -> irq_out stays 0 while pending=1.
- Wrap: COUNT=FFFFFFFE, COMPARE=5, PRESCALE=0, enable -> COUNT goes FFFFFFFF, 0, …, 5, then match; no pending at wrap.
- Oneshot (macro on): CTRL=7, COMPARE=2, PRESCALE=0 -> a single pending after 3 clocks, COUNT frozen at 0, CTRL reads 6. With the macro off, same stimulus -> CTRL reads 3 and pending repeats every 3 clocks.
- Enable toggle: clear enable at COUNT=7 -> COUNT holds 7 for 50 cycles. Re-enable -> counting resumes from 7 with pre_cnt restarted at 0.

Source files
------------

// File: rtl/timer_sched_ctrl_if.sv
// Single-cycle req/ack register bus between a peripheral-bus master and the timer.
interface timer_sched_ctrl_if;
  logic        req_in;
  logic        we_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;
  logic        ack_out;

  modport master (output req_in, we_in, addr_in, wdata_in, input rdata_out, ack_out);
  modport slave  (input req_in, we_in, addr_in, wdata_in, output rdata_out, ack_out);
endinterface

// File: rtl/timer_sched_ctrl.sv
// Programmable prescaled tick counter with compare-match level interrupt.
// Build option TIMER_SCHED_CTRL_ONESHOT_EN adds CTRL[2] oneshot mode and the DONE state.
module timer_sched_ctrl #(
  parameter int          ADDR_W       = 3,
  parameter logic [31:0] PRESCALE_RST = 32'd999
) (
  input  logic              clk_in,
  input  logic              reset_in,
  timer_sched_ctrl_if.slave bus,
  output logic [31:0]       time_clk_out,
  output logic              irq_out
);

  localparam logic [ADDR_W-1:0] IDX_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] IDX_PRESCALE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_COUNT    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] IDX_COMPARE  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] IDX_STATUS   = ADDR_W'(4);

  typedef enum logic [1:0] {
`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
    ST_DONE = 2'd2,
`endif
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
  } state_t;

  state_t            state;
  logic              ctrl_en;
  logic              ctrl_irq_en;
  logic              ctrl_oneshot;
  logic [31:0]       prescale;
  logic [31:0]       compare;
  logic [31:0]       count;
  logic [31:0]       pre_cnt;
  logic              pending;
  logic              ack_q;
  logic [31:0]       rdata_q;

  logic [ADDR_W-1:0] word_idx;
  logic              rd_req;
  logic              wr_req;
  logic              wr_ctrl;
  logic              wr_prescale;
  logic              wr_count;
  logic              wr_compare;
  logic              wr_status;
  logic              en_wr;
  logic              dis_wr;
  logic              tick;
  logic              match;
  logic [31:0]       rd_mux;
  logic              unused_addr;

`ifndef TIMER_SCHED_CTRL_ONESHOT_EN
  assign ctrl_oneshot = 1'b0;
`endif

  assign word_idx    = bus.addr_in[ADDR_W+1:2];
  assign unused_addr = ^{bus.addr_in[31:ADDR_W+2], bus.addr_in[1:0]};
  assign rd_req      = bus.req_in & ~bus.we_in;
  assign wr_req      = bus.req_in &  bus.we_in;
  assign wr_ctrl     = wr_req && (word_idx == IDX_CTRL);
  assign wr_prescale = wr_req && (word_idx == IDX_PRESCALE);
  assign wr_count    = wr_req && (word_idx == IDX_COUNT);
  assign wr_compare  = wr_req && (word_idx == IDX_COMPARE);
  assign wr_status   = wr_req && (word_idx == IDX_STATUS);
  assign en_wr       = wr_ctrl &&  bus.wdata_in[0];
  assign dis_wr      = wr_ctrl && ~bus.wdata_in[0];

  // A disabling CTRL write discards a coinciding tick; a COUNT write overrides its match.
  assign tick  = (state == ST_RUN) && (pre_cnt == prescale) && !dis_wr;
  assign match = tick && (count == compare) && !wr_count;

  always_comb begin
    rd_mux = 32'd0;
    case (word_idx)
      IDX_CTRL:     rd_mux = {29'd0, ctrl_oneshot, ctrl_irq_en, ctrl_en};
      IDX_PRESCALE: rd_mux = prescale;
      IDX_COUNT:    rd_mux = count;
      IDX_COMPARE:  rd_mux = compare;
      IDX_STATUS:   rd_mux = {31'd0, pending};
      default:      rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state        <= ST_IDLE;
      ctrl_en      <= 1'b0;
      ctrl_irq_en  <= 1'b0;
`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
      ctrl_oneshot <= 1'b0;
`endif
      prescale     <= PRESCALE_RST;
      compare      <= 32'hFFFF_FFFF;
      count        <= 32'd0;
      pre_cnt      <= 32'd0;
      pending      <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= 32'd0;
    end else begin
      ack_q   <= bus.req_in;
      rdata_q <= rd_req ? rd_mux : 32'd0;

      if (wr_ctrl) begin
        ctrl_en      <= bus.wdata_in[0];
        ctrl_irq_en  <= bus.wdata_in[1];
`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
        ctrl_oneshot <= bus.wdata_in[2];
`endif
      end
      if (wr_prescale) prescale <= bus.wdata_in;
      if (wr_compare)  compare  <= bus.wdata_in;

      // Hardware set beats the write-1-to-clear.
      if (match)
        pending <= 1'b1;
      else if (wr_status && bus.wdata_in[0])
        pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en_wr) state <= ST_RUN;
        end
        ST_RUN: begin
          if (dis_wr) begin
            state   <= ST_IDLE;
            pre_cnt <= 32'd0;
          end else begin
            pre_cnt <= (pre_cnt == prescale) ? 32'd0 : pre_cnt + 32'd1;
            if (match) begin
              count <= 32'd0;
`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
              if (ctrl_oneshot) begin
                state   <= ST_DONE;
                ctrl_en <= 1'b0;
              end
`endif
            end else if (tick) begin
              count <= count + 32'd1;
            end
          end
        end
`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
        ST_DONE: begin
          if (en_wr) state <= ST_RUN;
        end
`endif
        default: state <= ST_IDLE;
      endcase

      // Software writes to the timebase restart the prescaler and win over any tick.
      if (wr_prescale || wr_count) pre_cnt <= 32'd0;
      if (wr_count) count <= bus.wdata_in;
    end
  end

  assign bus.ack_out   = ack_q;
  assign bus.rdata_out = rdata_q;
  assign time_clk_out  = count;
  assign irq_out       = pending & ctrl_irq_en;

endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Randomized and directed bench for timer_sched_ctrl against a register-level reference model.
module tb_timer_sched_ctrl;

`ifdef TIMER_SCHED_CTRL_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] time_clk_out;
  logic        irq_out;

  int n_chk  = 0;
  int n_pass = 0;

  timer_sched_ctrl_if bus();

  timer_sched_ctrl #(.ADDR_W(3), .PRESCALE_RST(32'd999)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .bus          (bus.slave),
    .time_clk_out (time_clk_out),
    .irq_out      (irq_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: software-visible registers plus the prescale phase.
  bit          m_en, m_irq, m_one, m_pend;
  logic [31:0] m_ps, m_cmp, m_cnt, m_pre;
  logic        exp_ack;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_en = 0; m_irq = 0; m_one = 0; m_pend = 0;
    m_ps = 32'd999; m_cmp = 32'hFFFF_FFFF; m_cnt = 0; m_pre = 0;
    exp_ack = 0; exp_rdata = 0;
  endtask

  function automatic logic [31:0] m_read(input int idx);
    case (idx)
      0: return {29'd0, m_one, m_irq, m_en};
      1: return m_ps;
      2: return m_cnt;
      3: return m_cmp;
      4: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the timer as software sees it, given this cycle's bus access.
  task automatic m_step(input bit req, input bit we, input int idx, input logic [31:0] wd);
    bit          wr, stop, tick, hit;
    bit          n_en, n_one;
    logic [31:0] n_cnt, n_pre;
    exp_ack   = req;
    exp_rdata = (req && !we) ? m_read(idx) : 32'd0;
    wr    = req && we;
    stop  = wr && idx == 0 && !wd[0];
    tick  = m_en && !stop && (m_pre == m_ps);
    n_pre = (m_en && !stop && m_pre != m_ps) ? m_pre + 1 : 32'd0;
    n_cnt = m_cnt;
    hit   = 0;
    if (tick) begin
      if (m_cnt == m_cmp) begin n_cnt = 0; hit = 1; end
      else n_cnt = m_cnt + 1;
    end
    if (wr && idx == 2) begin n_cnt = wd; n_pre = 0; hit = 0; end
    if (wr && idx == 1) begin m_ps = wd; n_pre = 0; end
    if (wr && idx == 3) m_cmp = wd;
    n_en = m_en; n_one = m_one;
    if (wr && idx == 0) begin
      n_en  = wd[0];
      m_irq = wd[1];
      n_one = ONESHOT ? wd[2] : 1'b0;
    end
    if (hit && m_one) n_en = 0;
    if (hit) m_pend = 1;
    else if (wr && idx == 4 && wd[0]) m_pend = 0;
    m_en = n_en; m_one = n_one; m_cnt = n_cnt; m_pre = n_pre;
  endtask

  task automatic cyc(input bit req, input bit we, input int idx, input logic [31:0] wd);
    logic [31:0] a;
    a = $urandom();
    a[4:2] = 3'(idx);
    bus.req_in = req; bus.we_in = we; bus.addr_in = a; bus.wdata_in = wd;
    m_step(req, we, idx, wd);
    @(posedge clk_in); #1;
    bus.req_in = 1'b0;
    check("ack", {31'd0, bus.ack_out}, {31'd0, exp_ack});
    check("rdata", bus.rdata_out, exp_rdata);
    check("count", time_clk_out, m_cnt);
    check("irq", {31'd0, irq_out}, {31'd0, m_pend & m_irq});
  endtask

  task automatic wr(input int idx, input logic [31:0] wd); cyc(1, 1, idx, wd); endtask
  task automatic rd(input int idx); cyc(1, 0, idx, $urandom()); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'd0); endtask

  task automatic do_reset();
    reset_in = 1'b1; #1;
    check("rst_ack", {31'd0, bus.ack_out}, 32'd0);
    check("rst_rdata", bus.rdata_out, 32'd0);
    check("rst_count", time_clk_out, 32'd0);
    check("rst_irq", {31'd0, irq_out}, 32'd0);
    m_reset();
    @(posedge clk_in); #1;
    reset_in = 1'b0;
  endtask

  task automatic readback();
    rd(0); check("rb_ctrl", bus.rdata_out, 32'd0);
    rd(1); check("rb_prescale", bus.rdata_out, 32'd999);
    rd(2); check("rb_count", bus.rdata_out, 32'd0);
    rd(3); check("rb_compare", bus.rdata_out, 32'hFFFF_FFFF);
    rd(4); check("rb_status", bus.rdata_out, 32'd0);
    idle(1); check("rb_ack_drop", {31'd0, bus.ack_out}, 32'd0);
  endtask

  function automatic logic [31:0] rand_wdata(input int idx);
    case (idx)
      0: return $urandom_range(0, 7) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
      1: return $urandom_range(0, 3);
      2: return ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom_range(0, 8);
      3: return $urandom_range(0, 8);
      default: return $urandom();
    endcase
  endfunction

  initial begin
    bus.req_in = 0; bus.we_in = 0; bus.addr_in = 0; bus.wdata_in = 0;
    reset_in = 1'b1;
    m_reset();
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    readback();

    // Periodic: tick every 4 clocks, match on the fifth tick.
    wr(1, 3); wr(3, 4); wr(0, 3);
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      if (k < 20) begin
        check("per_cnt", time_clk_out, 32'(k / 4));
        check("per_noirq", {31'd0, irq_out}, 32'd0);
      end
    end
    check("per_irq20", {31'd0, irq_out}, 32'd1);
    check("per_wrap", time_clk_out, 32'd0);

    // Write-1-clear landing on the next match loses; one cycle later it wins.
    idle(19);
    wr(4, 1); check("w1c_race", {31'd0, irq_out}, 32'd1);
    wr(4, 1); check("w1c_clear", {31'd0, irq_out}, 32'd0);
    wr(0, 1);
    idle(25);
    check("masked_irq", {31'd0, irq_out}, 32'd0);
    rd(4); check("masked_pend", bus.rdata_out, 32'd1);

    // Wrap through all-ones without a match.
    wr(0, 0); wr(4, 1); wr(2, 32'hFFFF_FFFE); wr(3, 5); wr(1, 0); wr(0, 3);
    idle(1); check("wrap_ff", time_clk_out, 32'hFFFF_FFFF);
    idle(1); check("wrap_0", time_clk_out, 32'd0);
    check("wrap_nopend", {31'd0, irq_out}, 32'd0);
    idle(5); check("wrap_5", time_clk_out, 32'd5);
    idle(1); check("wrap_match", {31'd0, irq_out}, 32'd1);

    // Oneshot request: fires once when built with the option, otherwise periodic.
    wr(0, 0); wr(4, 1); wr(2, 0); wr(3, 2); wr(1, 0); wr(0, 7);
    idle(3); check("os_irq", {31'd0, irq_out}, 32'd1);
    rd(0); check("os_ctrl", bus.rdata_out, ONESHOT ? 32'd6 : 32'd3);
    wr(4, 1); check("os_clr", {31'd0, irq_out}, 32'd0);
    idle(1); check("os_repeat", {31'd0, irq_out}, ONESHOT ? 32'd0 : 32'd1);
    idle(1); check("os_frozen", time_clk_out, ONESHOT ? 32'd0 : 32'd1);

    // Enable toggle holds COUNT and restarts the prescaler on resume.
    wr(0, 0); wr(4, 1); wr(2, 0); wr(1, 1); wr(3, 100); wr(0, 3);
    for (int i = 0; i < 100 && time_clk_out != 32'd7; i++) idle(1);
    check("tog_reach7", time_clk_out, 32'd7);
    wr(0, 2);
    for (int i = 0; i < 50; i++) begin
      idle(1);
      check("tog_hold", time_clk_out, 32'd7);
    end
    wr(0, 3); check("tog_resume0", time_clk_out, 32'd7);
    idle(1);  check("tog_resume1", time_clk_out, 32'd7);
    idle(1);  check("tog_resume2", time_clk_out, 32'd8);

    // Randomized traffic, including back-to-back accesses.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        int idx;
        idx = $urandom_range(0, 7);
        if ($urandom_range(0, 1) == 1) wr(idx, rand_wdata(idx));
        else rd(idx);
      end else begin
        idle(1);
      end
    end

    // Reset arriving while an ack is on the bus, with the timer running.
    wr(1, 0); wr(3, 32'hFFFF_FFFF); wr(0, 3);
    bus.req_in = 1; bus.we_in = 0; bus.addr_in = 32'h8; bus.wdata_in = 0;
    m_step(1, 0, 2, 32'd0);
    @(posedge clk_in); #1;
    bus.req_in = 0;
    check("pre_rst_ack", {31'd0, bus.ack_out}, 32'd1);
    do_reset();
    readback();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
